// File: rtl/button_hall_panel_if.sv
// Call-button panel bus: raw buttons and controller handshakes in,
// request/lamp status and floor identity out.
interface button_hall_panel_if #(
  parameter int NUM_FLOORS = 8
);
  localparam int FLOOR_W = $clog2(NUM_FLOORS);

  logic               button_up;
  logic               button_down;
  logic               ack_up;
  logic               ack_down;
  logic               serviced_up;
  logic               serviced_down;
  logic               request_up;
  logic               request_down;
  logic               lamp_up;
  logic               lamp_down;
  logic [FLOOR_W-1:0] floor_id;

  // Controller / stimulus side.
  modport master (
    output button_up, button_down, ack_up, ack_down, serviced_up, serviced_down,
    input  request_up, request_down, lamp_up, lamp_down, floor_id
  );

  // Panel side.
  modport slave (
    input  button_up, button_down, ack_up, ack_down, serviced_up, serviced_down,
    output request_up, request_down, lamp_up, lamp_down, floor_id
  );
endinterface

// File: rtl/button_hall_panel.sv
// Hallway call-button panel: one independent Up/Down channel pair per floor.
// Each channel synchronises and debounces its button, raises a request, lights
// the lamp on ack and clears on service. End-floor channels are not built.

module button_hall_channel #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  input  logic ack,
  input  logic serviced,
  output logic request,
  output logic lamp
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, PENDING, LIT} state_t;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       settle_q, settle_d;
  logic             blocked_q, blocked_d;
  logic             press;
  state_t           state_q, state_d;
  logic             request_q, request_d;
  logic             lamp_q, lamp_d;

  // Synchroniser, saturating debounce counter and press-event detection.
  // The event fires on the edge where the counter reaches its maximum, so the
  // request registers on that same edge. After reset the channel stays blocked
  // until the synchroniser has refilled and shows a released button, so a
  // button held through reset cannot raise a new call.
  always_comb begin
    sync1_d = button;
    sync2_d = sync1_q;
    if (!sync2_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
    settle_d  = (settle_q == 2'd2) ? settle_q : settle_q + 2'd1;
    blocked_d = blocked_q && !((settle_q == 2'd2) && !sync2_q);
    press     = (cnt_d == CNT_MAX) && (cnt_q != CNT_MAX) && !blocked_q;
  end

  // Input-path state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      settle_q  <= '0;
      blocked_q <= 1'b1;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      settle_q  <= settle_d;
      blocked_q <= blocked_d;
    end
  end

  // Channel FSM next state; serviced beats ack while pending.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (press) state_d = PENDING;
      PENDING: begin
        if (serviced) begin
          state_d = IDLE;
        end else if (ack) begin
          state_d = LIT;
        end
      end
      LIT:     if (serviced) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    request_d = (state_d == PENDING);
    lamp_d    = (state_d == LIT);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      request_q <= 1'b0;
      lamp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      request_q <= request_d;
      lamp_q    <= lamp_d;
    end
  end

  assign request = request_q;
  assign lamp    = lamp_q;
endmodule

module button_hall_panel #(
  parameter int FLOOR           = 0,
  parameter int NUM_FLOORS      = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic                clk,
  input logic                reset,
  button_hall_panel_if.slave bus
);
  localparam int FLOOR_W = $clog2(NUM_FLOORS);

  if (NUM_FLOORS < 2) begin : g_bad_num_floors
    $error("button_hall_panel: NUM_FLOORS must be >= 2");
  end
  if (FLOOR >= NUM_FLOORS) begin : g_bad_floor
    $error("button_hall_panel: FLOOR must be < NUM_FLOORS");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_hall_panel: DEBOUNCE_CYCLES must be >= 1");
  end

  assign bus.floor_id = FLOOR_W'(FLOOR);

  if (FLOOR < NUM_FLOORS - 1) begin : g_up
    button_hall_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
      .clk      (clk),
      .reset    (reset),
      .button   (bus.button_up),
      .ack      (bus.ack_up),
      .serviced (bus.serviced_up),
      .request  (bus.request_up),
      .lamp     (bus.lamp_up)
    );
  end else begin : g_no_up
    logic unused_up;
    assign unused_up      = ^{bus.button_up, bus.ack_up, bus.serviced_up};
    assign bus.request_up = 1'b0;
    assign bus.lamp_up    = 1'b0;
  end

  if (FLOOR > 0) begin : g_down
    button_hall_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
      .clk      (clk),
      .reset    (reset),
      .button   (bus.button_down),
      .ack      (bus.ack_down),
      .serviced (bus.serviced_down),
      .request  (bus.request_down),
      .lamp     (bus.lamp_down)
    );
  end else begin : g_no_down
    logic unused_down;
    assign unused_down      = ^{bus.button_down, bus.ack_down, bus.serviced_down};
    assign bus.request_down = 1'b0;
    assign bus.lamp_down    = 1'b0;
  end
endmodule

// File: tb/tb_button_hall_panel.sv
// Bench for button_hall_panel: three panels (floors 3, 7, 0) share one set of
// inputs and are checked every cycle against a behavioural model.
module tb_button_hall_panel;
  localparam int D    = 4;
  localparam int MAXC = 8192;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_up = 1'b0, btn_down = 1'b0;
  logic ack_up = 1'b0, ack_down = 1'b0;
  logic serviced_up = 1'b0, serviced_down = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  button_hall_panel_if #(.NUM_FLOORS(8)) bus0 ();
  button_hall_panel_if #(.NUM_FLOORS(8)) bus1 ();
  button_hall_panel_if #(.NUM_FLOORS(8)) bus2 ();

  assign bus0.button_up = btn_up;       assign bus0.button_down = btn_down;
  assign bus0.ack_up = ack_up;          assign bus0.ack_down = ack_down;
  assign bus0.serviced_up = serviced_up; assign bus0.serviced_down = serviced_down;
  assign bus1.button_up = btn_up;       assign bus1.button_down = btn_down;
  assign bus1.ack_up = ack_up;          assign bus1.ack_down = ack_down;
  assign bus1.serviced_up = serviced_up; assign bus1.serviced_down = serviced_down;
  assign bus2.button_up = btn_up;       assign bus2.button_down = btn_down;
  assign bus2.ack_up = ack_up;          assign bus2.ack_down = ack_down;
  assign bus2.serviced_up = serviced_up; assign bus2.serviced_down = serviced_down;

  button_hall_panel #(.FLOOR(3), .NUM_FLOORS(8), .DEBOUNCE_CYCLES(D)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));
  button_hall_panel #(.FLOOR(7), .NUM_FLOORS(8), .DEBOUNCE_CYCLES(D)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));
  button_hall_panel #(.FLOOR(0), .NUM_FLOORS(8), .DEBOUNCE_CYCLES(D)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance and direction: 0 = no call, 1 = call waiting for ack, 2 = lamp lit.
  int  st [3][2];
  bit  en [3][2];
  int  run [2];      // consecutive high samples seen since reset
  bit  armed [2];    // a released-button sample has been seen since reset
  bit  hist_u [MAXC];
  bit  hist_d [MAXC];
  int  cyc = 0;
  int  vstart = 1 << 30;
  bit  mon = 1'b0;

  initial begin
    en[0][0] = 1'b1; en[0][1] = 1'b1;   // floor 3: both channels
    en[1][0] = 1'b0; en[1][1] = 1'b1;   // floor 7: no Up
    en[2][0] = 1'b1; en[2][1] = 1'b0;   // floor 0: no Down
  end

  task automatic model_step();
    bit ev [2];
    bit b, a, s;
    cyc++;
    if (cyc < MAXC) begin
      hist_u[cyc] = btn_up;
      hist_d[cyc] = btn_down;
    end
    if (reset) begin
      for (int i = 0; i < 3; i++) for (int c = 0; c < 2; c++) st[i][c] = 0;
      for (int c = 0; c < 2; c++) begin run[c] = 0; armed[c] = 1'b0; end
      vstart = cyc + 1;
      mon = 1'b1;
    end else begin
      // A button sample reaches the debouncer two edges after it is taken;
      // a press is the D-th consecutive high sample after a released sample.
      for (int c = 0; c < 2; c++) begin
        ev[c] = 1'b0;
        if (cyc - 2 >= vstart && cyc - 2 < MAXC) begin
          b = (c == 1) ? hist_d[cyc-2] : hist_u[cyc-2];
          if (b) begin
            if (run[c] < 1000) run[c]++;
            if (run[c] == D && armed[c]) ev[c] = 1'b1;
          end else begin
            run[c] = 0;
            armed[c] = 1'b1;
          end
        end
      end
      for (int i = 0; i < 3; i++) begin
        for (int c = 0; c < 2; c++) begin
          if (en[i][c]) begin
            a = (c == 1) ? ack_down : ack_up;
            s = (c == 1) ? serviced_down : serviced_up;
            if (st[i][c] == 0) begin
              if (ev[c]) st[i][c] = 1;
            end else if (st[i][c] == 1) begin
              if (s) st[i][c] = 0;
              else if (a) st[i][c] = 2;
            end else begin
              if (s) st[i][c] = 0;
            end
          end
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  function automatic logic [31:0] mreq(input int i, input int c);
    return (st[i][c] == 1) ? 32'd1 : 32'd0;
  endfunction
  function automatic logic [31:0] mlamp(input int i, input int c);
    return (st[i][c] == 2) ? 32'd1 : 32'd0;
  endfunction

  // Per-cycle comparison of every panel against the model.
  always @(negedge clk) begin
    if (mon) begin
      check("i0_req_up",  bus0.request_up,   mreq(0, 0));
      check("i0_req_dn",  bus0.request_down, mreq(0, 1));
      check("i0_lamp_up", bus0.lamp_up,      mlamp(0, 0));
      check("i0_lamp_dn", bus0.lamp_down,    mlamp(0, 1));
      check("i1_req_up",  bus1.request_up,   mreq(1, 0));
      check("i1_req_dn",  bus1.request_down, mreq(1, 1));
      check("i1_lamp_up", bus1.lamp_up,      mlamp(1, 0));
      check("i1_lamp_dn", bus1.lamp_down,    mlamp(1, 1));
      check("i2_req_up",  bus2.request_up,   mreq(2, 0));
      check("i2_req_dn",  bus2.request_down, mreq(2, 1));
      check("i2_lamp_up", bus2.lamp_up,      mlamp(2, 0));
      check("i2_lamp_dn", bus2.lamp_down,    mlamp(2, 1));
      check("i0_floor_id", bus0.floor_id, 32'd3);
      check("i1_floor_id", bus1.floor_id, 32'd7);
      check("i2_floor_id", bus2.floor_id, 32'd0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rises;
    logic prev;
    int rem_u, rem_d;

    repeat (2) tick();
    reset = 1'b0;
    check("rst_req_up", bus0.request_up, 1'b0);
    check("rst_lamp_dn", bus0.lamp_down, 1'b0);
    repeat (5) tick();

    // Up press latency: first sampled at edge k, request after edge k+1+D.
    btn_up = 1'b1;
    repeat (1 + D) tick();
    check("lat_req_up_early", bus0.request_up, 1'b0);
    tick();
    check("lat_req_up", bus0.request_up, 1'b1);
    check("lat_lamp_up", bus0.lamp_up, 1'b0);
    check("model_pend_up", st[0][0], 32'd1);
    check("top_floor_req_up", bus1.request_up, 1'b0);
    repeat (3) tick();
    ack_up = 1'b1; tick(); ack_up = 1'b0;
    check("ack_req_up", bus0.request_up, 1'b0);
    check("ack_lamp_up", bus0.lamp_up, 1'b1);
    check("model_lit_up", st[0][0], 32'd2);
    check("top_floor_lamp_up", bus1.lamp_up, 1'b0);
    repeat (9) tick();
    serviced_up = 1'b1; tick(); serviced_up = 1'b0;
    check("svc_lamp_up", bus0.lamp_up, 1'b0);
    repeat (5) tick();
    check("held_no_repress", bus0.request_up, 1'b0);
    btn_up = 1'b0;
    repeat (4) tick();

    // Glitch shorter than D samples.
    btn_down = 1'b1; repeat (D - 1) tick(); btn_down = 1'b0;
    repeat (10) tick();
    check("glitch_req_dn", bus0.request_down, 1'b0);

    // Long hold: exactly one request edge.
    btn_down = 1'b1;
    rises = 0;
    prev = bus0.request_down;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (!prev && bus0.request_down) rises++;
      prev = bus0.request_down;
    end
    check("hold_rises_dn", rises, 32'd1);
    ack_down = 1'b1; tick(); ack_down = 1'b0;
    check("hold_lamp_dn", bus0.lamp_down, 1'b1);
    btn_down = 1'b0; repeat (3) tick();
    btn_down = 1'b1; repeat (10) tick();
    check("lit_repress_lamp", bus0.lamp_down, 1'b1);
    check("lit_repress_req", bus0.request_down, 1'b0);
    btn_down = 1'b0;
    serviced_down = 1'b1; tick(); serviced_down = 1'b0;
    check("svc_lamp_dn", bus0.lamp_down, 1'b0);
    repeat (4) tick();

    // ack and serviced together while pending: serviced wins.
    btn_down = 1'b1; repeat (D + 2) tick();
    check("pend_req_dn", bus0.request_down, 1'b1);
    ack_down = 1'b1; serviced_down = 1'b1; tick();
    ack_down = 1'b0; serviced_down = 1'b0;
    check("both_req_dn", bus0.request_down, 1'b0);
    check("both_lamp_dn", bus0.lamp_down, 1'b0);
    btn_down = 1'b0; repeat (4) tick();

    // Simultaneous presses on both channels.
    btn_up = 1'b1; btn_down = 1'b1;
    repeat (1 + D) tick();
    check("sim_early_up", bus0.request_up, 1'b0);
    check("sim_early_dn", bus0.request_down, 1'b0);
    tick();
    check("sim_i0_up", bus0.request_up, 1'b1);
    check("sim_i0_dn", bus0.request_down, 1'b1);
    check("sim_i1_up", bus1.request_up, 1'b0);
    check("sim_i1_dn", bus1.request_down, 1'b1);
    check("sim_i2_up", bus2.request_up, 1'b1);
    check("sim_i2_dn", bus2.request_down, 1'b0);
    ack_up = 1'b1; tick(); ack_up = 1'b0;
    check("sim_i0_lamp_up", bus0.lamp_up, 1'b1);
    check("sim_i1_lamp_up", bus1.lamp_up, 1'b0);

    // Reset with Up lit, Down pending and both buttons still held.
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst_lamp_up", bus0.lamp_up, 1'b0);
    check("mid_rst_req_dn", bus0.request_down, 1'b0);
    check("mid_rst_i2_lamp_up", bus2.lamp_up, 1'b0);
    repeat (20) tick();
    check("held_after_rst_dn", bus0.request_down, 1'b0);
    check("held_after_rst_up", bus0.request_up, 1'b0);
    btn_up = 1'b0; btn_down = 1'b0; repeat (3) tick();
    btn_down = 1'b1;
    repeat (D + 1) tick();
    check("repress_early_dn", bus0.request_down, 1'b0);
    tick();
    check("repress_req_dn", bus0.request_down, 1'b1);
    btn_down = 1'b0;
    serviced_down = 1'b1; tick(); serviced_down = 1'b0;
    repeat (4) tick();

    // Randomised traffic, checked against the model every cycle.
    rem_u = 0; rem_d = 0;
    for (int n = 0; n < 2500; n++) begin
      if (rem_u == 0) begin
        btn_up = ~btn_up;
        rem_u = btn_up ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 8));
      end
      rem_u--;
      if (rem_d == 0) begin
        btn_down = ~btn_down;
        rem_d = btn_down ? int'($urandom_range(1, 12)) : int'($urandom_range(1, 8));
      end
      rem_d--;
      ack_up        = ($urandom_range(0, 9) == 0);
      ack_down      = ($urandom_range(0, 9) == 0);
      serviced_up   = ($urandom_range(0, 14) == 0);
      serviced_down = ($urandom_range(0, 14) == 0);
      reset         = ($urandom_range(0, 399) == 0);
      tick();
    end
    btn_up = 1'b0; btn_down = 1'b0;
    ack_up = 1'b0; ack_down = 1'b0;
    serviced_up = 1'b0; serviced_down = 1'b0; reset = 1'b0;
    repeat (5) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/button_hall_panel.md
Name: button_hall_panel

Overview:
- Hallway call-button panel for one floor with independent Up and Down channels.
- Each channel synchronises and debounces its button, latches a call request to the building controller, lights the direction lamp once the controller acks, and clears when a car services that direction.
- The floor position is parametrised. The Up channel is disabled on the top floor and the Down channel on the bottom floor, so one module serves every floor.

Parameters:
- FLOOR, 0, floor index of this panel, 0 = bottom.
- NUM_FLOORS, 8, number of floors in the building. Must be >= 2; FLOOR must be < NUM_FLOORS.
- DEBOUNCE_CYCLES, 4, consecutive synchronised-high samples required to accept a press. Must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- button_up  input  1  raw Up pushbutton, asynchronous, active-high.
- button_down  input  1  raw Down pushbutton, asynchronous, active-high.
- ack_up  input  1  controller accepts the Up call; one-cycle pulse.
- ack_down  input  1  controller accepts the Down call; one-cycle pulse.
- serviced_up  input  1  car arrived at this floor travelling up; one-cycle pulse.
- serviced_down  input  1  car arrived at this floor travelling down; one-cycle pulse.
- request_up  output  1  Up call pending, not yet acked.
- request_down  output  1  Down call pending, not yet acked.
- lamp_up  output  1  Up call acknowledged; lamp lit.
- lamp_down  output  1  Down call acknowledged; lamp lit.
- floor_id  output  $clog2(NUM_FLOORS)  constant FLOOR, for the controller's request decode.

Behaviour:
- Reset (synchronous, clk edge with reset=1):
  - All synchronisers, debounce counters and channel FSMs are cleared.
  - request_*=0, lamp_*=0.
  - floor_id is constant at all times.
  - Reset mid-operation drops any pending or lit call immediately. No call is regenerated until the button is released and pressed again.
- Per-channel input path:
  - A 2-flop synchroniser feeds a saturating debounce counter of width $clog2(DEBOUNCE_CYCLES+1).
  - A synchronised 1 increments the counter, saturating at DEBOUNCE_CYCLES. A synchronised 0 clears it.
  - The debounced level is 1 while the counter equals DEBOUNCE_CYCLES.
  - A press event is the 0->1 transition of the debounced level: exactly one event per press.
  - A button held indefinitely produces a single event.
  - Glitches shorter than DEBOUNCE_CYCLES synchronised samples produce none.
- Press latency:
  - If the button is first sampled high at edge k and held, request_* is high after edge k+1+DEBOUNCE_CYCLES.
- Channel FSM, with states IDLE, PENDING and LIT:
  - IDLE: request=0, lamp=0.
    - A press event moves to PENDING.
    - ack and serviced are ignored.
  - PENDING: request=1, lamp=0.
    - ack moves to LIT.
    - serviced moves to IDLE (car arrived before the controller acked).
    - If ack and serviced arrive in the same cycle, serviced wins and the state moves to IDLE.
    - Further press events are ignored.
  - LIT: request=0, lamp=1.
    - serviced moves to IDLE.
    - ack and press events are ignored.
  - If a press event and serviced arrive in the same cycle in IDLE, the state moves to PENDING; serviced has no effect in IDLE.
  - All outputs are registered and decoded directly from state. No combinational path runs from any input to any output.
- End floors:
  - FLOOR == NUM_FLOORS-1: the Up channel is permanently IDLE, request_up=lamp_up=0, and button_up, ack_up and serviced_up are ignored.
  - FLOOR == 0: the same applies to the Down channel.
  - The disabled channel's logic is removed by generate.
- Channel independence:
  - The Up and Down channels are fully independent; both may be PENDING or LIT at once.
  - Simultaneous presses on both channels register both calls in the same cycle.
- Elaboration assertions (simulation):
  - Fail if NUM_FLOORS < 2.
  - Fail if FLOOR >= NUM_FLOORS.
  - Fail if DEBOUNCE_CYCLES < 1.

Test Plan:
- FLOOR=3, NUM_FLOORS=8, DEBOUNCE_CYCLES=4; hold button_up high from edge 10 -> request_up rises after edge 15, lamp_up=0. Pulse ack_up at edge 20 -> request_up=0, lamp_up=1 after edge 20. Pulse serviced_up at edge 30 -> lamp_up=0.
- Glitch: button_down high for 3 cycles then low -> request_down stays 0. Button held 100 cycles -> exactly one 0->1 on request_down; press again while LIT -> no change.
- Simultaneous: in PENDING, assert ack_down and serviced_down in the same cycle -> request_down=0, lamp_down=0 (IDLE). Both buttons pressed together -> request_up and request_down rise on the same edge.
- End floors: FLOOR=7, NUM_FLOORS=8, press button_up and pulse ack_up -> request_up=lamp_up=0 throughout, Down channel works normally. FLOOR=0 -> Down channel inert, Up channel works; floor_id equals FLOOR in both cases.
- Reset mid-operation: Up LIT and Down PENDING, assert reset 1 cycle while button_down is still held -> all outputs 0 after that edge. No new request_down until button_down is released and re-pressed (request after DEBOUNCE_CYCLES+2 edges).
